spi_cfg_sequencer: RTL

Upstream word-level master for the SPI serializer. It holds a small table of configuration words for the image-sensor front end. On start it pushes each word through the serializer's SDO valid/ready handshake. When verify is enabled, it reads each word back through the SDI handshake and compares it with the table entry. It reports completion, timeout and mismatch status to the control logic.

---
 rtl/spi_cfg_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: walks a small configuration table and pushes each word
// through the SPI serializer's SDO handshake. With verify enabled, it reads
// each word back over SDI and compares it with the table entry.
module spi_cfg_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_we_i,
  input  logic [AW-1:0]         tbl_addr_i,
  input  logic [DATA_WIDTH-1:0] tbl_wdata_i,
  input  logic                  start_i,
  input  logic [AW:0]           num_words_i,
  input  logic                  verify_en_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  timeout_o,
  output logic [AW-1:0]         err_idx_o,
  output logic [7:0]            mismatch_cnt_o,
  output logic [DATA_WIDTH-1:0] rdback_o,
  output logic [DATA_WIDTH-1:0] sdo_data_o,
  output logic                  sdo_valid_o,
  input  logic                  sdo_ready_i,
  input  logic [DATA_WIDTH-1:0] sdi_data_i,
  input  logic                  sdi_valid_i,
  output logic                  sdi_ready_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_READ,
    S_CHECK,
    S_NEXT,
    S_FIN
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] tbl [DEPTH];
  logic [AW:0]           idx;
  logic [AW:0]           count;
  logic [AW:0]           idx_nxt;
  logic [AW:0]           num_clamped;
  logic                  verify;
  logic [TW-1:0]         tcnt;
  logic                  tout_hit;

  assign idx_nxt     = idx + (AW+1)'(1);
  assign num_clamped = (num_words_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_words_i;
  assign tout_hit    = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Configuration table: writable only while no sequence is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
        tbl[i] <= '0;
      end
    end else if (tbl_we_i && !busy_o) begin
      tbl[tbl_addr_i] <= tbl_wdata_i;
    end
  end

  // Sequencer FSM with registered outputs and per-wait-state timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      count          <= '0;
      verify         <= 1'b0;
      tcnt           <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      timeout_o      <= 1'b0;
      err_idx_o      <= '0;
      mismatch_cnt_o <= '0;
      rdback_o       <= '0;
      sdo_data_o     <= '0;
      sdo_valid_o    <= 1'b0;
      sdi_ready_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            count          <= num_clamped;
            verify         <= verify_en_i;
            err_o          <= 1'b0;
            timeout_o      <= 1'b0;
            mismatch_cnt_o <= '0;
            err_idx_o      <= '0;
            idx            <= '0;
            if (num_clamped == '0) begin
              done_o <= 1'b1;
              state  <= S_FIN;
            end else begin
              busy_o      <= 1'b1;
              sdo_data_o  <= tbl[0];
              sdo_valid_o <= 1'b1;
              state       <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          sdo_valid_o <= 1'b0;
          tcnt        <= '0;
          state       <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (sdo_ready_i) begin
            tcnt  <= '0;
            state <= S_WAIT_DONE;
          end else if (tout_hit) begin
            err_o     <= 1'b1;
            timeout_o <= 1'b1;
            if (!err_o) err_idx_o <= idx[AW-1:0];
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!sdo_ready_i) begin
            tcnt <= '0;
            if (verify) begin
              sdi_ready_o <= 1'b1;
              state       <= S_READ;
            end else begin
              state <= S_NEXT;
            end
          end else if (tout_hit) begin
            err_o     <= 1'b1;
            timeout_o <= 1'b1;
            if (!err_o) err_idx_o <= idx[AW-1:0];
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_READ: begin
          if (sdi_valid_i) begin
            rdback_o    <= sdi_data_i;
            sdi_ready_o <= 1'b0;
            state       <= S_CHECK;
          end else if (tout_hit) begin
            err_o       <= 1'b1;
            timeout_o   <= 1'b1;
            if (!err_o) err_idx_o <= idx[AW-1:0];
            sdi_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state       <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_CHECK: begin
          if (rdback_o != tbl[idx[AW-1:0]]) begin
            if (mismatch_cnt_o != 8'hFF) mismatch_cnt_o <= mismatch_cnt_o + 8'd1;
            err_o <= 1'b1;
            if (!err_o) err_idx_o <= idx[AW-1:0];
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          idx <= idx_nxt;
          if (idx_nxt == count) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_FIN;
          end else begin
            sdo_data_o  <= tbl[idx_nxt[AW-1:0]];
            sdo_valid_o <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
